vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates the 640x480@60 Hz raster for the display pipeline. It produces the pixel coordinates, the visible-area flag and the sync pulses that every sprite/ROM rendering stage consumes. It also produces frame-level pulses and an animation frame index, so game logic and sprite selection update only at frame boundaries. It sits directly upstream of the sprite renderers and drives DrawX, DrawY and blank into them.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- ANIM_DIV, 6, frames per animation step; legal range 1..255
- vga_clk  in  1  pixel clock. One pixel per cycle. Single clock domain.
- reset_n  in  1  synchronous, active-low reset
- DrawX  out  10  current horizontal position, 0..H_TOTAL-1
- DrawY  out  10  current vertical position, 0..V_TOTAL-1
- blank  out  1  1 = visible pixel (DrawX < H_VISIBLE and DrawY < V_VISIBLE); 0 = blanking
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- frame_start  out  1  one-cycle pulse at position (0,0)
- vblank_start  out  1  one-cycle pulse at position (0,V_VISIBLE)
- anim_tick  out  1  one-cycle pulse on every ANIM_DIV-th frame_start
- anim_frame  out  4  animation index; increments on anim_tick and wraps 15->0

## Operation
- Derived constants:
  - H_TOTAL = sum of the H_* parameters (800 by default).
  - V_TOTAL = sum of the V_* parameters (525 by default).
  - Both totals must be <= 1024. Elaboration fails otherwise.
- Internal position (hc, vc):
  - hc increments every cycle and wraps H_TOTAL-1 -> 0.
  - On each hc wrap, vc increments and wraps V_TOTAL-1 -> 0.
- All outputs are registered and mutually aligned. In the cycle DrawX=x, DrawY=y, the signals blank, hs, vs and the pulses all describe position (x,y). Decode is therefore done from next-state position.
- hs = 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC. Default: 656..751.
- vs = 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC. Default: 490..491. vs is a full-line quantity, independent of DrawX.
- Animation divider (div, 8 bits):
  - On each frame_start: if div == ANIM_DIV-1, set div to 0, assert anim_tick and increment anim_frame in that same cycle. Otherwise increment div.
  - The new anim_frame value is visible in the same cycle as anim_tick, so it is stable for the whole frame that follows.
  - ANIM_DIV=1 gives anim_tick on every frame_start.
- Reset, while reset_n=0 at a rising edge:
  - Internal position is set to (H_TOTAL-1, V_TOTAL-1); div=0.
  - Outputs: DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_start=0, vblank_start=0, anim_tick=0, anim_frame=0.
- Reset asserted mid-frame aborts the frame immediately. Outputs take reset values on the next edge. There are no partial pulses.

## Timing
- Latency from reset release: at the first rising edge with reset_n=1, outputs show DrawX=0, DrawY=0, blank=1, frame_start=1.
- Frame period: H_TOTAL*V_TOTAL cycles, which is 420000 by default. The frame_start pulses are exactly that far apart.
- Line timing:
  - Default line = 800 cycles.
  - blank is high for 640 consecutive cycles on lines 0..479 and low on every cycle of lines 480..524.
  - hs is low for 96 consecutive cycles per line, on every line including vertical blanking.
- vblank_start occurs V_VISIBLE*H_TOTAL cycles after frame_start (384000 by default).
- Downstream ROM stages read on the negative edge. Coordinates are stable for a full vga_clk period from each rising edge.
- anim_tick never occurs without frame_start in the same cycle. The first anim_tick after reset is the ANIM_DIV-th frame_start, counting the first post-reset cycle as frame 1.

## Test plan
- Release reset, run 1 cycle -> DrawX=0, DrawY=0, blank=1, frame_start=1, hs=1, vs=1, anim_frame=0.
- Run one line from (0,0) -> blank high for DrawX 0..639; hs low exactly DrawX 656..751 (96 cycles); DrawX wraps 799->0 with DrawY 0->1.
- Run one full frame -> vblank_start once at (0,480), 384000 cycles after frame_start; vs low for exactly 1600 cycles (lines 490..491); next frame_start 420000 cycles after the first.
- ANIM_DIV=2, run 34 frames -> anim_tick on frames 2,4,...,34, each coincident with frame_start; anim_frame reaches 15 at frame 30, wraps to 0 at frame 32, reads 1 at frame 34.
- Assert reset_n=0 for 1 cycle at (300,200) -> next edge shows reset values; after release, frame_start at (0,0); div restarts (first anim_tick on the ANIM_DIV-th frame after release).
- Small parameters H=(8,2,2,2), V=(4,1,1,1) -> H_TOTAL=14, V_TOTAL=7, frame period 98 cycles; hs low DrawX 10..11, vs low DrawY 5.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz raster generator: pixel coordinates, visible flag, active-low syncs,
// frame/vblank pulses and a frame-rate animation index, all registered and aligned.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int ANIM_DIV  = 6
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       vblank_start,
  output logic       anim_tick,
  output logic [3:0] anim_frame
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (ANIM_DIV < 1 || ANIM_DIV > 255) begin : g_anim_div_check
    $error("vga_timing_gen: ANIM_DIV must be in 1..255");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Thresholds are 11 bits so a region ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEG    = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] VS_BEG    = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [7:0]  DIV_LAST  = 8'(ANIM_DIV - 1);

  // hc/vc hold the position currently shown on DrawX/DrawY; reset parks them on the
  // last pixel so the first post-reset edge wraps to (0,0).
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic [7:0]  div;

  logic [9:0]  hc_nxt;
  logic [9:0]  vc_nxt;
  logic [10:0] hx;
  logic [10:0] vy;
  logic        h_wrap;
  logic        blank_nxt;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        fs_nxt;
  logic        vb_nxt;

  always_comb begin
    h_wrap = (hc == H_LAST);
    hc_nxt = h_wrap ? 10'd0 : hc + 10'd1;
    vc_nxt = vc;
    if (h_wrap) begin
      vc_nxt = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    end
  end

  // Decode from the next position so every output lines up with DrawX/DrawY.
  always_comb begin
    hx        = {1'b0, hc_nxt};
    vy        = {1'b0, vc_nxt};
    blank_nxt = (hx < H_VIS_END) && (vy < V_VIS_END);
    hs_nxt    = !((hx >= HS_BEG) && (hx < HS_END));
    vs_nxt    = !((vy >= VS_BEG) && (vy < VS_END));
    fs_nxt    = (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
    vb_nxt    = (hc_nxt == 10'd0) && (vy == V_VIS_END);
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc           <= H_LAST;
      vc           <= V_LAST;
      div          <= 8'd0;
      DrawX        <= 10'd0;
      DrawY        <= 10'd0;
      blank        <= 1'b0;
      hs           <= 1'b1;
      vs           <= 1'b1;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      anim_tick    <= 1'b0;
      anim_frame   <= 4'd0;
    end else begin
      hc           <= hc_nxt;
      vc           <= vc_nxt;
      DrawX        <= hc_nxt;
      DrawY        <= vc_nxt;
      blank        <= blank_nxt;
      hs           <= hs_nxt;
      vs           <= vs_nxt;
      frame_start  <= fs_nxt;
      vblank_start <= vb_nxt;
      anim_tick    <= 1'b0;
      // The new anim_frame appears together with anim_tick, stable for the whole frame.
      if (fs_nxt) begin
        if (div == DIV_LAST) begin
          div        <= 8'd0;
          anim_tick  <= 1'b1;
          anim_frame <= anim_frame + 4'd1;
        end else begin
          div <= div + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a tiny-raster instance, each
// compared every cycle against a position-from-cycle-count reference model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       vb;
    logic       tick;
    logic [3:0] af;
  } obs_t;

  typedef struct {
    int         t;
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
  } vec_t;

  // Instance A: default 640x480 timing, ANIM_DIV=6.
  localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33, A_DIV = 6;
  // Instance B: 14x7 raster, ANIM_DIV=2.
  localparam int B_HV = 8, B_HF = 2, B_HS = 2, B_HB = 2;
  localparam int B_VV = 4, B_VF = 1, B_VS = 1, B_VB = 1, B_DIV = 2;
  localparam int B_FRAME = 98;

  logic vga_clk;
  logic rst_a;
  logic rst_b;

  logic [9:0] dx_a, dy_a, dx_b, dy_b;
  logic       bl_a, hs_a, vs_a, fs_a, vb_a, tk_a;
  logic       bl_b, hs_b, vs_b, fs_b, vb_b, tk_b;
  logic [3:0] af_a, af_b;
  obs_t       obs_a, obs_b;

  int checks = 0;
  int errors = 0;
  int ta = 0;
  int tb_t = 0;
  int hs_lo_a = 0, blank_hi_a = 0;
  int vs_lo_b = 0, vb_cnt_b = 0, tick_cnt_b = 0;
  vec_t tbl[11];

  vga_timing_gen #(
    .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB), .ANIM_DIV(A_DIV)
  ) dut_a (
    .vga_clk(vga_clk), .reset_n(rst_a), .DrawX(dx_a), .DrawY(dy_a), .blank(bl_a),
    .hs(hs_a), .vs(vs_a), .frame_start(fs_a), .vblank_start(vb_a),
    .anim_tick(tk_a), .anim_frame(af_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB), .ANIM_DIV(B_DIV)
  ) dut_b (
    .vga_clk(vga_clk), .reset_n(rst_b), .DrawX(dx_b), .DrawY(dy_b), .blank(bl_b),
    .hs(hs_b), .vs(vs_b), .frame_start(fs_b), .vblank_start(vb_b),
    .anim_tick(tk_b), .anim_frame(af_b)
  );

  assign obs_a = {dx_a, dy_a, bl_a, hs_a, vs_a, fs_a, vb_a, tk_a, af_a};
  assign obs_b = {dx_b, dy_b, bl_b, hs_b, vs_b, fs_b, vb_b, tk_b, af_b};

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // t = number of rising edges since reset release (0 while in reset).
  function automatic obs_t model(int t, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb, int adiv);
    obs_t o;
    int ht, vt, p, x, y, f;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (t == 0) return o;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p  = (t - 1) % (ht * vt);
    x  = p % ht;
    y  = p / ht;
    f  = (t - 1) / (ht * vt) + 1;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.blank = (x < hv) && (y < vv);
    o.hs    = !((x >= hv + hf) && (x < hv + hf + hsw));
    o.vs    = !((y >= vv + vf) && (y < vv + vf + vsw));
    o.fs    = (p == 0);
    o.vb    = (x == 0) && (y == vv);
    o.tick  = o.fs && (f % adiv == 0);
    o.af    = 4'((f / adiv) % 16);
    return o;
  endfunction

  task automatic check_obs(string name, int t, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d act x=%0d y=%0d bl=%0b hs=%0b vs=%0b fs=%0b vb=%0b tk=%0b af=%0d exp x=%0d y=%0d bl=%0b hs=%0b vs=%0b fs=%0b vb=%0b tk=%0b af=%0d",
               name, t, act.x, act.y, act.blank, act.hs, act.vs, act.fs, act.vb, act.tick, act.af,
               exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.fs, exp.vb, exp.tick, exp.af);
    end
  endtask

  task automatic check_val(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
    ta   = rst_a ? ta + 1 : 0;
    tb_t = rst_b ? tb_t + 1 : 0;
    check_obs("model_a", ta, obs_a, model(ta, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_DIV));
    check_obs("model_b", tb_t, obs_b, model(tb_t, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_DIV));
    if (ta >= 1 && ta <= 800) begin
      hs_lo_a    += (hs_a == 1'b0) ? 1 : 0;
      blank_hi_a += (bl_a == 1'b1) ? 1 : 0;
    end
    if (tb_t >= 1 && tb_t <= B_FRAME) begin
      vs_lo_b  += (vs_b == 1'b0) ? 1 : 0;
      vb_cnt_b += (vb_b == 1'b1) ? 1 : 0;
    end
    if (tb_t >= 1 && tb_t <= 34 * B_FRAME) tick_cnt_b += (tk_b == 1'b1) ? 1 : 0;
  endtask

  task automatic run_a_to(int target);
    for (int n = 0; n < 20000 && ta < target; n++) step();
    check_val("reach_a", ta, target);
  endtask

  task automatic run_b_to(int target);
    for (int n = 0; n < 20000 && tb_t < target; n++) step();
    check_val("reach_b", tb_t, target);
  endtask

  initial begin
    obs_t e;
    int n, d;
    tbl[0]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{640,  10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{641,  10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{656,  10'd655, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{657,  10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{752,  10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{753,  10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{800,  10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{801,  10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1441, 10'd640, 10'd1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{2401, 10'd0,   10'd3, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) step();
    check_val("rst_a_hs", int'(hs_a), 1);
    check_val("rst_a_x", int'(dx_a), 0);

    // Default timing: table of line landmarks after release.
    rst_a = 1'b1;
    for (int i = 0; i < 11; i++) begin
      run_a_to(tbl[i].t);
      e = '0;
      e.x = tbl[i].x; e.y = tbl[i].y; e.blank = tbl[i].blank;
      e.hs = tbl[i].hs; e.vs = tbl[i].vs; e.fs = tbl[i].fs;
      check_obs("tbl_a", ta, obs_a, e);
    end
    check_val("a_hs_low_line0", hs_lo_a, 96);
    check_val("a_blank_hi_line0", blank_hi_a, 640);

    // Mid-frame reset of A at (300,3).
    run_a_to(3 * 800 + 300 + 1);
    check_val("a_pre_rst_x", int'(dx_a), 300);
    check_val("a_pre_rst_y", int'(dy_a), 3);
    rst_a = 1'b0;
    step();
    check_val("a_rst_x", int'(dx_a), 0);
    check_val("a_rst_blank", int'(bl_a), 0);
    check_val("a_rst_fs", int'(fs_a), 0);
    rst_a = 1'b1;
    step();
    check_val("a_rel_fs", int'(fs_a), 1);
    check_val("a_rel_blank", int'(bl_a), 1);

    // Tiny raster, ANIM_DIV=2, 34 frames.
    hs_lo_a = 0; blank_hi_a = 0;
    rst_b = 1'b1;
    run_b_to(11);  check_val("b_hs_x10", int'(hs_b), 0);
    run_b_to(12);  check_val("b_hs_x11", int'(hs_b), 0);
    run_b_to(13);  check_val("b_hs_x12", int'(hs_b), 1);
    run_b_to(57);  check_val("b_vb_pulse", int'(vb_b), 1);
    check_val("b_vb_y", int'(dy_b), 4);
    run_b_to(70);  check_val("b_vs_y4", int'(vs_b), 1);
    run_b_to(71);  check_val("b_vs_y5", int'(vs_b), 0);
    run_b_to(85);  check_val("b_vs_y6", int'(vs_b), 1);
    run_b_to(99);  check_val("b_fs_frame2", int'(fs_b), 1);
    check_val("b_tick_frame2", int'(tk_b), 1);
    check_val("b_af_frame2", int'(af_b), 1);
    run_b_to(29 * B_FRAME + 1); check_val("b_af_frame30", int'(af_b), 15);
    run_b_to(31 * B_FRAME + 1); check_val("b_af_frame32", int'(af_b), 0);
    run_b_to(33 * B_FRAME + 1); check_val("b_af_frame34", int'(af_b), 1);
    check_val("b_tick_frame34", int'(tk_b), 1);
    run_b_to(34 * B_FRAME);
    check_val("b_tick_count", tick_cnt_b, 17);
    check_val("b_vs_low_frame1", vs_lo_b, 14);
    check_val("b_vb_count_frame1", vb_cnt_b, 1);

    // Mid-frame reset of B at (5,3): divider must restart.
    run_b_to(34 * B_FRAME + 3 * 14 + 5 + 1);
    check_val("b_pre_rst_x", int'(dx_b), 5);
    check_val("b_pre_rst_y", int'(dy_b), 3);
    rst_b = 1'b0;
    step();
    check_val("b_rst_af", int'(af_b), 0);
    rst_b = 1'b1;
    step();
    check_val("b_rel_fs", int'(fs_b), 1);
    check_val("b_rel_tick", int'(tk_b), 0);
    run_b_to(99);
    check_val("b_rel_tick_frame2", int'(tk_b), 1);
    check_val("b_rel_af_frame2", int'(af_b), 1);

    // Random reset pulses on either instance, model checked every cycle.
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(1, 300);
      repeat (n) step();
      d = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) rst_a = 1'b0;
      else rst_b = 1'b0;
      repeat (d) step();
      rst_a = 1'b1;
      rst_b = 1'b1;
    end
    repeat (300) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
